// File: rtl/rv6_bus_resp.sv
// Responder end of the rv6 core data bus: line fills, external dword reads and sized
// writes from a 64-bit on-chip RAM, plus a write-invalidate broadcast and an AMO lock.
module rv6_bus_resp #(
    parameter int unsigned LINE_W    = 256,
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic              c_clk,
    input  logic              c_rst,
    input  logic [63:0]       c_addr,
    input  logic              c_ext,
    input  logic              c_rd,
    input  logic              c_wr,
    input  logic [63:0]       c_wdata,
    input  logic [1:0]        c_len,
    output logic [LINE_W-1:0] c_rdata,
    output logic              c_dv,
    output logic [63:0]       c_inv_addr,
    output logic              c_inv,
    input  logic              c_amo_req,
    output logic              c_amo_ack
);
    localparam int unsigned NBEATS    = LINE_W / 64;
    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam int unsigned CW        = $clog2(NBEATS + 1);
    localparam logic [63:0] LINE_MASK = 64'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RSP  = 3'd3,
        HOLD = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [63:0]       addr_q, addr_d;
    logic              ext_q, ext_d;
    logic [1:0]        len_q, len_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              wr_op_q, wr_op_d;
    logic [63:0]       inv_addr_q, inv_addr_d;
    logic              ack_q, ack_d;
    logic              dv_q, dv_d;
    logic              inv_q, inv_d;
    logic [LINE_W-1:0] rdata_q;
    logic [63:0]       mem_q [MEM_WORDS];

    logic [CW-1:0]     last_cnt;
    logic              rd_issue;
    logic [AW-1:0]     rd_idx;
    logic [AW-1:0]     wr_idx;
    logic [2:0]        wr_off;
    logic [7:0]        be_base;
    logic [7:0]        wr_be;
    logic [63:0]       wr_lane;

    // RD spends one extra cycle after the last beat so the final word lands with c_dv
    assign last_cnt = ext_q ? CW'(1) : CW'(NBEATS);
    assign rd_issue = (state_q == RD) && (cnt_q != last_cnt);
    assign rd_idx   = addr_q[3 +: AW] + AW'(cnt_q);
    assign wr_idx   = addr_q[3 +: AW];

    // Byte enables: offset aligned down to the access size, data shifted into its lanes
    always_comb begin
        wr_off  = 3'd0;
        be_base = 8'hFF;
        unique case (len_q)
            2'd0: begin wr_off = addr_q[2:0];              be_base = 8'h01; end
            2'd1: begin wr_off = {addr_q[2:1], 1'b0};      be_base = 8'h03; end
            2'd2: begin wr_off = {addr_q[2], 2'b00};       be_base = 8'h0F; end
            default: begin wr_off = 3'd0;                  be_base = 8'hFF; end
        endcase
        wr_be   = be_base << wr_off;
        wr_lane = wdata_q << {wr_off, 3'b000};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        ext_d      = ext_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        wr_op_d    = wr_op_q;
        inv_addr_d = inv_addr_q;
        ack_d      = c_amo_req & (ack_q | (state_q == IDLE) | (state_q == HOLD));
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (c_rd) begin
                    state_d = RD;
                    wr_op_d = 1'b0;
                    ext_d   = c_ext;
                    addr_d  = c_ext ? (c_addr & ~64'd7) : (c_addr & ~LINE_MASK);
                end else if (c_wr) begin
                    state_d = WR;
                    wr_op_d = 1'b1;
                    addr_d  = c_addr;
                    len_d   = c_len;
                    wdata_d = c_wdata;
                end
            end
            RD: begin
                if (cnt_q == last_cnt) state_d = RSP;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            WR: begin
                state_d    = RSP;
                inv_addr_d = addr_q & ~LINE_MASK;
            end
            RSP:     state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        dv_d  = (state_d == RSP);
        inv_d = (state_d == RSP) & wr_op_q;
    end

    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            ext_q      <= 1'b0;
            len_q      <= 2'd0;
            wdata_q    <= '0;
            wr_op_q    <= 1'b0;
            inv_addr_q <= '0;
            ack_q      <= 1'b0;
            dv_q       <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ext_q      <= ext_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            wr_op_q    <= wr_op_d;
            inv_addr_q <= inv_addr_d;
            ack_q      <= ack_d;
            dv_q       <= dv_d;
            inv_q      <= inv_d;
        end
    end

    // Read beats land in their slot one cycle after issue; ext reads clear the upper line
    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            rdata_q <= '0;
        end else if (rd_issue) begin
            if (ext_q) rdata_q <= LINE_W'(mem_q[rd_idx]);
            else       rdata_q[64*cnt_q +: 64] <= mem_q[rd_idx];
        end
    end

    always_ff @(posedge c_clk) begin
        if (state_q == WR) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_lane[8*b +: 8];
            end
        end
    end

    assign c_rdata    = rdata_q;
    assign c_dv       = dv_q;
    assign c_inv      = inv_q;
    assign c_inv_addr = inv_addr_q;
    assign c_amo_ack  = ack_q;

endmodule
